// File: rtl/frame_source_pkg.sv
// Shared frame geometry and gray depth for the frame source and the VGA engine.
// Also holds the state type of the bank-swap controller.
package frame_source_pkg;

    localparam int FS_PIXELS     = 64;
    localparam int FS_GRAY_WIDTH = 4;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_t;

endpackage

// File: rtl/frame_source_bank.sv
// One PIXELS x GRAY_WIDTH pixel bank.
// Synchronous write port, combinational read port; contents are never reset.
module frame_bank #(
    parameter int PIXELS     = 64,
    parameter int GRAY_WIDTH = 4,
    parameter int ADDR_WIDTH = $clog2(PIXELS)
) (
    input  logic                  clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [GRAY_WIDTH-1:0] i_wr_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [GRAY_WIDTH-1:0] o_rd_data
);

    logic [GRAY_WIDTH-1:0] r_mem [PIXELS];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/frame_source.sv
// Double-buffered frame source: streams the front bank to the VGA engine and
// swaps banks only on a frame restart so the display never shows a torn frame.
module frame_source
    import frame_source_pkg::*;
#(
    parameter int PIXELS     = FS_PIXELS,
    parameter int GRAY_WIDTH = FS_GRAY_WIDTH,
    parameter int ADDR_WIDTH = $clog2(PIXELS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_next_pixel_in,
    input  logic                  frame_reset_in,
    output logic [GRAY_WIDTH-1:0] frame_pixel_out,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [GRAY_WIDTH-1:0] wr_data,
    input  logic                  swap_req,
    output logic                  swap_pending,
    output logic                  swap_done,
    output logic                  front_bank,
    output logic [7:0]            frame_count,
    output logic                  ptr_wrap
);

    swap_state_t           r_state;
    swap_state_t           w_state_next;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic                  w_ptr_last;
    logic                  w_wrap_next;
    logic                  r_front_bank;
    logic                  w_front_next;
    logic                  w_do_swap;
    logic                  w_swap_pending;
    logic                  w_wr_in_range;
    logic [GRAY_WIDTH-1:0] r_pixel;
    logic                  r_swap_done;
    logic                  r_ptr_wrap;
    logic [7:0]            r_frame_count;
    logic [1:0]            w_bank_we;
    logic [GRAY_WIDTH-1:0] w_rd_data [2];

    // Read pointer: restart beats advance, last pixel wraps to 0
    assign w_ptr_last  = (r_ptr == ADDR_WIDTH'(PIXELS - 1));
    assign w_wrap_next = !frame_reset_in && frame_next_pixel_in && w_ptr_last;

    always_comb begin
        w_ptr_next = r_ptr;
        if (frame_reset_in) begin
            w_ptr_next = '0;
        end else if (frame_next_pixel_in) begin
            w_ptr_next = w_ptr_last ? '0 : r_ptr + ADDR_WIDTH'(1);
        end
    end

    // Swap controller, state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SWAP_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Swap controller, next state; a request coinciding with a restart swaps at once
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SWAP_IDLE: begin
                if (swap_req && !frame_reset_in) begin
                    w_state_next = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (frame_reset_in) begin
                    w_state_next = SWAP_IDLE;
                end
            end
            default: w_state_next = SWAP_IDLE;
        endcase
    end

    // Swap controller, outputs
    always_comb begin
        w_swap_pending = (r_state == SWAP_PENDING);
        w_do_swap      = frame_reset_in && (w_swap_pending || swap_req);
    end

    assign w_front_next  = r_front_bank ^ w_do_swap;
    assign w_wr_in_range = ({1'b0, wr_addr} < (ADDR_WIDTH + 1)'(PIXELS));

    // Only the bank that is the back bank at the start of the cycle is writable
    for (genvar b = 0; b < 2; b++) begin : g_bank
        assign w_bank_we[b] = wr_en && w_wr_in_range && (r_front_bank != 1'(b));

        frame_bank #(
            .PIXELS     (PIXELS),
            .GRAY_WIDTH (GRAY_WIDTH),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk       (clk),
            .i_wr_en   (w_bank_we[b]),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_addr (w_ptr_next),
            .o_rd_data (w_rd_data[b])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr         <= '0;
            r_front_bank  <= 1'b0;
            r_pixel       <= '0;
            r_swap_done   <= 1'b0;
            r_ptr_wrap    <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_ptr        <= w_ptr_next;
            r_front_bank <= w_front_next;
            r_pixel      <= w_rd_data[w_front_next];
            r_swap_done  <= w_do_swap;
            r_ptr_wrap   <= w_wrap_next;
            if (frame_reset_in) begin
                r_frame_count <= r_frame_count + 8'd1;
            end
        end
    end

    assign frame_pixel_out = r_pixel;
    assign swap_pending    = w_swap_pending;
    assign swap_done       = r_swap_done;
    assign front_bank      = r_front_bank;
    assign frame_count     = r_frame_count;
    assign ptr_wrap        = r_ptr_wrap;

endmodule
